// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register slave: FSM state encoding and
// the R/W bit values carried in the address byte.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        PTR      = 4'd3,
        PTR_ACK  = 4'd4,
        WR       = 4'd5,
        WR_ACK   = 4'd6,
        RD       = 4'd7,
        RD_ACK   = 4'd8
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and produces registered SCL edge
// strobes plus START/STOP condition strobes.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_val,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync_r;
    logic [1:0] sda_sync_r;
    logic       scl_prev_r;
    logic       sda_prev_r;

    // Synchronisers reset to the idle-bus level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
            scl_rise   <= 1'b0;
            scl_fall   <= 1'b0;
            sda_val    <= 1'b1;
            start      <= 1'b0;
            stop       <= 1'b0;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl};
            sda_sync_r <= {sda_sync_r[0], sda};
            scl_prev_r <= scl_sync_r[1];
            sda_prev_r <= sda_sync_r[1];
            scl_rise   <= scl_sync_r[1] & ~scl_prev_r;
            scl_fall   <= ~scl_sync_r[1] & scl_prev_r;
            sda_val    <= sda_sync_r[1];
            start      <= scl_sync_r[1] & scl_prev_r & sda_prev_r & ~sda_sync_r[1];
            stop       <= scl_sync_r[1] & scl_prev_r & ~sda_prev_r & sda_sync_r[1];
        end
    end

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C slave exposing a small register file: write = pointer byte then data
// bytes, read = data from the current pointer, auto-incrementing and wrapping.
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 16,
    parameter int         PTR_W      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             scl,
    inout  wire              sda,
    output logic [PTR_W-1:0] reg_addr_o,
    output logic [7:0]       reg_wdata_o,
    output logic             reg_we_o,
    output logic             reg_re_o,
    input  logic [7:0]       reg_rdata_i,
    output logic             addressed_o,
    output logic             stop_o
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

    logic scl_rise_s;
    logic scl_fall_s;
    logic sda_val_s;
    logic start_s;
    logic stop_s;

    i2c_state_e       state_r;
    logic [3:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic [6:0]       tx_r;
    logic [PTR_W-1:0] ptr_r;
    logic             sda_drive_r;
    logic             rw_r;
    logic             ack_r;
    logic             load_r;

    i2c_bus_sync u_bus_sync (
        .clk      (clk),
        .resetn   (resetn),
        .scl      (scl),
        .sda      (sda),
        .scl_rise (scl_rise_s),
        .scl_fall (scl_fall_s),
        .sda_val  (sda_val_s),
        .start    (start_s),
        .stop     (stop_s)
    );

    assign sda = sda_drive_r ? 1'b0 : 1'bz;

    // Protocol FSM: bits sampled on SCL rise, all drive changes on SCL fall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 4'd0;
            shift_r     <= 8'h00;
            tx_r        <= 7'h00;
            ptr_r       <= '0;
            sda_drive_r <= 1'b0;
            rw_r        <= I2C_RW_WRITE;
            ack_r       <= 1'b0;
            load_r      <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= 8'h00;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            addressed_o <= 1'b0;
            stop_o      <= 1'b0;
        end else begin
            reg_we_o <= 1'b0;
            reg_re_o <= 1'b0;
            stop_o   <= 1'b0;
            load_r   <= 1'b0;
            // Read data arrives one cycle after the request; MSB goes out at once.
            if (load_r) begin
                tx_r        <= reg_rdata_i[6:0];
                sda_drive_r <= ~reg_rdata_i[7];
            end
            if (stop_s) begin
                state_r     <= IDLE;
                sda_drive_r <= 1'b0;
                bit_cnt_r   <= 4'd0;
                load_r      <= 1'b0;
                stop_o      <= addressed_o;
                addressed_o <= 1'b0;
            end else if (start_s) begin
                state_r     <= ADDR;
                sda_drive_r <= 1'b0;
                bit_cnt_r   <= 4'd0;
                load_r      <= 1'b0;
                addressed_o <= 1'b0;
            end else if (scl_rise_s) begin
                case (state_r)
                    ADDR, PTR, WR: begin
                        shift_r   <= {shift_r[6:0], sda_val_s};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end
                    RD:      bit_cnt_r <= bit_cnt_r + 4'd1;
                    RD_ACK:  ack_r     <= ~sda_val_s;
                    default: ack_r     <= ack_r;
                endcase
            end else if (scl_fall_s) begin
                case (state_r)
                    ADDR: begin
                        if (bit_cnt_r == 4'd8) begin
                            bit_cnt_r <= 4'd0;
                            if (shift_r[7:1] == SLAVE_ADDR) begin
                                sda_drive_r <= 1'b1;
                                addressed_o <= 1'b1;
                                rw_r        <= shift_r[0];
                                state_r     <= ADDR_ACK;
                            end else begin
                                state_r     <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        sda_drive_r <= 1'b0;
                        if (rw_r == I2C_RW_READ) begin
                            reg_re_o   <= 1'b1;
                            reg_addr_o <= ptr_r;
                            load_r     <= 1'b1;
                            state_r    <= RD;
                        end else begin
                            state_r    <= PTR;
                        end
                    end
                    PTR: begin
                        if (bit_cnt_r == 4'd8) begin
                            bit_cnt_r   <= 4'd0;
                            ptr_r       <= shift_r[PTR_W-1:0];
                            sda_drive_r <= 1'b1;
                            state_r     <= PTR_ACK;
                        end
                    end
                    PTR_ACK: begin
                        sda_drive_r <= 1'b0;
                        state_r     <= WR;
                    end
                    WR: begin
                        if (bit_cnt_r == 4'd8) begin
                            bit_cnt_r   <= 4'd0;
                            reg_we_o    <= 1'b1;
                            reg_addr_o  <= ptr_r;
                            reg_wdata_o <= shift_r;
                            sda_drive_r <= 1'b1;
                            state_r     <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        sda_drive_r <= 1'b0;
                        ptr_r       <= ptr_r + PTR_ONE;
                        state_r     <= WR;
                    end
                    RD: begin
                        if (bit_cnt_r == 4'd8) begin
                            bit_cnt_r   <= 4'd0;
                            sda_drive_r <= 1'b0;
                            state_r     <= RD_ACK;
                        end else begin
                            tx_r        <= {tx_r[5:0], 1'b0};
                            sda_drive_r <= ~tx_r[6];
                        end
                    end
                    RD_ACK: begin
                        if (ack_r) begin
                            ptr_r      <= ptr_r + PTR_ONE;
                            reg_re_o   <= 1'b1;
                            reg_addr_o <= ptr_r + PTR_ONE;
                            load_r     <= 1'b1;
                            state_r    <= RD;
                        end else begin
                            sda_drive_r <= 1'b0;
                            state_r     <= IDLE;
                        end
                    end
                    default: begin
                        sda_drive_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Randomised bench for i2c_reg_slave: a bit-banged master, a register-file
// responder and an array/pointer reference model of the slave's behaviour.
module tb_i2c_reg_slave;

    localparam int NUM_REGS = 16;
    localparam int Q        = 8;

    logic       clk = 1'b0;
    logic       resetn;
    logic       scl_m;
    logic       m_drive;
    wire        sda;
    logic [3:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic       reg_re_o;
    logic [7:0] reg_rdata_i = 8'h00;
    logic       addressed_o;
    logic       stop_o;

    assign sda = m_drive ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_reg_slave #(.SLAVE_ADDR(7'h50), .NUM_REGS(NUM_REGS)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .scl         (scl_m),
        .sda         (sda),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_rdata_i (reg_rdata_i),
        .addressed_o (addressed_o),
        .stop_o      (stop_o)
    );

    // Environment register file and event logs, owned by this block only.
    logic [7:0]  regs [NUM_REGS] = '{default: 8'h00};
    logic [11:0] we_q [$];
    int          re_q [$];
    int          overlap_cnt = 0;
    int          stop_cnt = 0;
    int          addr_cnt = 0;
    int          slave_low_cnt = 0;

    always @(negedge clk) begin
        if (reg_we_o) begin
            regs[reg_addr_o] = reg_wdata_o;
            we_q.push_back({reg_addr_o, reg_wdata_o});
        end
        if (reg_re_o) begin
            reg_rdata_i = regs[reg_addr_o];
            re_q.push_back(int'(reg_addr_o));
        end
        if (reg_we_o && reg_re_o) overlap_cnt++;
        if (stop_o) stop_cnt++;
        if (addressed_o) addr_cnt++;
        if (sda === 1'b0 && !m_drive) slave_low_cnt++;
    end

    // Reference model: register contents and the pointer as the spec defines them.
    logic [7:0] mdl_mem [NUM_REGS] = '{default: 8'h00};
    int         mdl_ptr = 0;

    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic write_bit(input logic b);
        m_drive = ~b;
        tick(Q); scl_m = 1'b1; tick(2*Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_drive = 1'b0;
        tick(Q); scl_m = 1'b1; tick(Q);
        b = (sda === 1'b0) ? 1'b0 : 1'b1;
        tick(Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_start();
        m_drive = 1'b0; tick(Q); scl_m = 1'b1; tick(Q);
        m_drive = 1'b1; tick(Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_drive = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
        m_drive = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic send_ack, output logic [7:0] d);
        logic r;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(r);
            d = {d[6:0], r};
        end
        write_bit(~send_ack);
    endtask

    task automatic do_write(input logic [7:0] p, input logic [7:0] data[$]);
        logic        ack;
        int          we_base;
        int          st_base;
        logic [11:0] exp_we [$];
        we_base = we_q.size();
        st_base = stop_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        chk_eq("wr_addr_ack", ack, 1'b1);
        chk_eq("wr_addressed", addressed_o, 1'b1);
        write_byte(p, ack);
        chk_eq("wr_ptr_ack", ack, 1'b1);
        mdl_ptr = int'(p) % NUM_REGS;
        foreach (data[i]) begin
            write_byte(data[i], ack);
            chk_eq("wr_data_ack", ack, 1'b1);
            mdl_mem[mdl_ptr] = data[i];
            exp_we.push_back({4'(mdl_ptr), data[i]});
            mdl_ptr = (mdl_ptr + 1) % NUM_REGS;
        end
        i2c_stop();
        tick(4*Q);
        chk_eq("we_count", we_q.size() - we_base, exp_we.size());
        for (int i = 0; i < exp_we.size() && we_base + i < we_q.size(); i++)
            chk_eq("we_entry", we_q[we_base+i], exp_we[i]);
        chk_eq("wr_stop_pulse", stop_cnt - st_base, 1);
        chk_eq("wr_addressed_clr", addressed_o, 1'b0);
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] d;
        int         re_base;
        int         st_base;
        int         exp_re [$];
        re_base = re_q.size();
        st_base = stop_cnt;
        i2c_start();
        if (set_ptr) begin
            write_byte(8'hA0, ack);
            chk_eq("rp_addr_ack", ack, 1'b1);
            write_byte(p, ack);
            chk_eq("rp_ptr_ack", ack, 1'b1);
            mdl_ptr = int'(p) % NUM_REGS;
            i2c_start();
        end
        write_byte(8'hA1, ack);
        chk_eq("rd_addr_ack", ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, d);
            chk_eq("rd_data", d, mdl_mem[mdl_ptr]);
            exp_re.push_back(mdl_ptr);
            if (i < n - 1) mdl_ptr = (mdl_ptr + 1) % NUM_REGS;
        end
        tick(2*Q);
        chk_eq("nack_release", sda, 1'b1);
        i2c_stop();
        tick(4*Q);
        chk_eq("re_count", re_q.size() - re_base, n);
        for (int i = 0; i < n && re_base + i < re_q.size(); i++)
            chk_eq("re_addr", re_q[re_base+i], exp_re[i]);
        chk_eq("rd_stop_pulse", stop_cnt - st_base, 1);
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] dq [$];
        int         n;
        int         we_base;
        int         re_base;
        int         st_base;
        int         low_base;
        int         ad_base;

        m_drive = 1'b0;
        scl_m   = 1'b1;
        resetn  = 1'b0;
        tick(5);
        chk_eq("rst_we", reg_we_o, 1'b0);
        chk_eq("rst_re", reg_re_o, 1'b0);
        chk_eq("rst_stop", stop_o, 1'b0);
        chk_eq("rst_addressed", addressed_o, 1'b0);
        chk_eq("rst_addr", reg_addr_o, 4'h0);
        chk_eq("rst_wdata", reg_wdata_o, 8'h00);
        chk_eq("rst_sda", sda, 1'b1);
        resetn = 1'b1;
        tick(5);

        // Single write, then a burst that wraps past the last register.
        dq = {}; dq.push_back(8'hAA);
        do_write(8'h03, dq);
        dq = {}; dq.push_back(8'h11); dq.push_back(8'h22); dq.push_back(8'h33);
        do_write(8'h0E, dq);

        // Random read with repeated START; reg 7 is zero so a late drive would show.
        dq = {}; dq.push_back(8'hCC); dq.push_back(8'hDD); dq.push_back(8'h00);
        do_write(8'h05, dq);
        do_read(1'b1, 8'h05, 2);

        // Random writes followed by reads continuing from the persistent pointer.
        for (int it = 0; it < 4; it++) begin
            n  = $urandom_range(1, 4);
            dq = {};
            repeat (n) dq.push_back(8'($urandom));
            do_write(8'($urandom), dq);
            do_read(1'b0, 8'h00, $urandom_range(1, 3));
        end

        // Foreign address: the slave must stay silent.
        we_base = we_q.size(); re_base = re_q.size(); st_base = stop_cnt;
        low_base = slave_low_cnt; ad_base = addr_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        chk_eq("wa_addr_nack", ack, 1'b0);
        write_byte(8'($urandom), ack);
        chk_eq("wa_data_nack", ack, 1'b0);
        i2c_stop();
        tick(4*Q);
        chk_eq("wa_sda_low", slave_low_cnt - low_base, 0);
        chk_eq("wa_we", we_q.size() - we_base, 0);
        chk_eq("wa_re", re_q.size() - re_base, 0);
        chk_eq("wa_addressed", addr_cnt - ad_base, 0);
        chk_eq("wa_stop", stop_cnt - st_base, 0);

        // STOP after four data bits discards the partial byte.
        we_base = we_q.size(); st_base = stop_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        chk_eq("ab_addr_ack", ack, 1'b1);
        write_byte(8'h07, ack);
        chk_eq("ab_ptr_ack", ack, 1'b1);
        mdl_ptr = 7;
        for (int i = 0; i < 4; i++) write_bit(1'($urandom));
        i2c_stop();
        tick(4*Q);
        chk_eq("ab_we", we_q.size() - we_base, 0);
        chk_eq("ab_addressed", addressed_o, 1'b0);
        chk_eq("ab_stop", stop_cnt - st_base, 1);
        write_byte(8'hA0, ack);
        chk_eq("ab_idle_ignore", ack, 1'b0);
        i2c_stop();
        tick(2*Q);

        // Reset while the slave drives a zero read bit.
        dq = {}; dq.push_back(8'h00);
        do_write(8'h09, dq);
        re_base = re_q.size();
        i2c_start();
        write_byte(8'hA0, ack);
        chk_eq("rs_addr_ack", ack, 1'b1);
        write_byte(8'h09, ack);
        chk_eq("rs_ptr_ack", ack, 1'b1);
        i2c_start();
        write_byte(8'hA1, ack);
        chk_eq("rs_rd_ack", ack, 1'b1);
        read_bit(b);
        chk_eq("rs_bit0", b, 1'b0);
        read_bit(b);
        chk_eq("rs_bit1", b, 1'b0);
        chk_eq("rs_re_addr", (re_q.size() > re_base) ? re_q[re_base] : -1, 9);
        m_drive = 1'b0;
        tick(Q); scl_m = 1'b1; tick(2);
        chk_eq("rs_pre_low", sda, 1'b0);
        resetn = 1'b0;
        #1;
        chk_eq("rs_sda_release", sda, 1'b1);
        chk_eq("rs_we", reg_we_o, 1'b0);
        chk_eq("rs_re", reg_re_o, 1'b0);
        chk_eq("rs_addressed", addressed_o, 1'b0);
        chk_eq("rs_addr", reg_addr_o, 4'h0);
        chk_eq("rs_wdata", reg_wdata_o, 8'h00);
        tick(3);
        resetn = 1'b1;
        mdl_ptr = 0;
        tick(Q); scl_m = 1'b0; tick(Q);
        we_base = we_q.size(); re_base = re_q.size(); st_base = stop_cnt;
        write_byte(8'hA0, ack);
        chk_eq("rs_no_start_ignore", ack, 1'b0);
        i2c_stop();
        tick(4*Q);
        chk_eq("rs_post_we", we_q.size() - we_base, 0);
        chk_eq("rs_post_re", re_q.size() - re_base, 0);
        chk_eq("rs_post_stop", stop_cnt - st_base, 0);
        do_read(1'b0, 8'h00, 1);

        chk_eq("we_re_overlap", overlap_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_reg_slave.md
I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50: 7-bit bus address matched.
REQ-002 SHALL have parameter NUM_REGS, default 16: register count, a power of two, at least 2.
REQ-003 SHALL have parameter PTR_W, default $clog2(NUM_REGS): register pointer width.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; SCL is oversampled on it.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port scl, input, 1 bit: I2C clock (the block never stretches it).
REQ-007 SHALL have port sda, inout, 1 bit: open-drain, driven 0 or Z only.
REQ-008 SHALL have port reg_addr_o, output, PTR_W bits: register index for the current access.
REQ-009 SHALL have port reg_wdata_o, output, 8 bits: byte received from the master.
REQ-010 SHALL have port reg_we_o, output, 1 bit: one-cycle write strobe.
REQ-011 SHALL have port reg_re_o, output, 1 bit: one-cycle read request.
REQ-012 SHALL have port reg_rdata_i, input, 8 bits: read data, valid the cycle after reg_re_o.
REQ-013 SHALL have port addressed_o, output, 1 bit: high from address ACK until STOP or START.
REQ-014 SHALL have port stop_o, output, 1 bit: one-cycle pulse on a STOP that ends an addressed transfer.

Function
REQ-015 SHALL pass scl and sda through 2-flop synchronisers and derive rise/fall strobes from the synchronised values.
REQ-016 SHALL detect START as an sda fall while scl is high, and STOP as an sda rise while scl is high; both take priority over bit handling in any state.
REQ-017 SHALL sample sda on the scl rise and change its own drive only on the scl fall.
REQ-018 SHALL use FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK.
- START -> ADDR from any state, including a repeated START.
- STOP -> IDLE from any state.
REQ-019 In ADDR, after 8 bits: if the address matches, SHALL drive ACK and assert addressed_o; otherwise SHALL go to IDLE with sda never driven.
REQ-020 A matched write (R/W=0) SHALL take its first data byte as the pointer: PTR -> PTR_ACK (ACK) -> WR.
REQ-021 In WR, after 8 bits, SHALL pulse reg_we_o with reg_addr_o=ptr and the received byte on reg_wdata_o, ACK, then increment ptr.
REQ-022 A matched read (R/W=1) SHALL pulse reg_re_o with reg_addr_o=ptr on the ACK scl fall, then register reg_rdata_i and shift it out MSB-first in RD.
REQ-023 In RD_ACK:
- master ACK (sda=0): increment ptr, pulse reg_re_o, go to RD.
- master NACK: release sda, go to IDLE-wait (ignore bits until START/STOP).
REQ-024 The pointer SHALL wrap from NUM_REGS-1 to 0. Pointer bytes SHALL be truncated to PTR_W bits.
REQ-025 The pointer SHALL persist across transfers, so a read without a pointer write continues from the last ptr.
REQ-026 STOP or START mid-byte SHALL discard the partial byte with no reg_we_o pulse.
REQ-027 At most one reg_we_o or reg_re_o pulse SHALL occur per byte. The two are never high in the same cycle.
REQ-028 The slave SHALL release sda no later than the scl fall ending each ACK or read-data bit.

Reset
REQ-029 On resetn=0, asynchronously:
- state=IDLE, sda released, ptr=0.
- reg_we_o=0, reg_re_o=0, stop_o=0, addressed_o=0.
- reg_addr_o=0, reg_wdata_o=0.
- shift and bit counters=0.
REQ-030 Reset mid-transfer SHALL release sda immediately. After release, the slave SHALL act only after a fresh START.

Structure
REQ-031 SHALL place the FSM state enum and the I2C_RW_READ/I2C_RW_WRITE constants in the shared package i2c_pkg.
REQ-032 SHALL use one sub-module, i2c_bus_sync: the synchronisers, edge strobes and START/STOP detection.

Verification
REQ-033 Write test: S 0xA0, ptr 0x03, data 0xAA, P -> three ACKs; reg_we_o once with addr 3 and data 0xAA; stop_o once.
REQ-034 Burst write test (NUM_REGS=16): ptr 0x0E, data 0x11 0x22 0x33 -> writes to 0xE, 0xF, then 0x0 (wrap).
REQ-035 Random read test: S 0xA0, ptr 5, Sr 0xA1, bench returns 0xCC for reg 5 and 0xDD for reg 6; master ACKs then NACKs -> master receives 0xCC then 0xDD; sda released after the NACK.
REQ-036 Wrong-address test: S 0xA2, data -> sda never driven low; no strobes; addressed_o stays 0.
REQ-037 Abort test: STOP after 4 bits of a data byte -> no reg_we_o; IDLE.
REQ-038 Reset test: resetn low during the RD phase with sda held 0 -> sda Z the same cycle; outputs at reset values.
